// File: rtl/mux_nto1_pipe.sv
// N-to-1 operand select with a registered output and 2-entry skid; 1-cycle latency, ready_o from state only.
// Optional out-of-range select counter built when MUX_SEL_ERR_CNT_EN is defined.
module mux_nto1_pipe #(
  parameter int SIZE   = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_IN*SIZE-1:0] data_i,
  input  logic [SEL_W-1:0]       select_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [SIZE-1:0]        data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [7:0]             err_cnt_o
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]      state;
  logic [SIZE-1:0] skid;
  logic [SIZE-1:0] sel_data;
  logic            accept;
  logic            pop;

  // Out-of-range selects fall through to input 0.
  always_comb begin
    sel_data = data_i[0 +: SIZE];
    for (int k = 1; k < NUM_IN; k++) begin
      if (select_i == SEL_W'(k)) sel_data = data_i[k*SIZE +: SIZE];
    end
  end

  assign ready_o = (state != FULL);
  assign valid_o = (state != EMPTY);
  assign accept  = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= EMPTY;
      data_o <= '0;
      skid   <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            data_o <= sel_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            data_o <= sel_data;
          end else if (accept) begin
            skid  <= sel_data;
            state <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            data_o <= skid;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef MUX_SEL_ERR_CNT_EN
  logic [7:0] err_cnt;
  logic       sel_oor;

  assign sel_oor = (32'(select_i) >= NUM_IN);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_cnt <= '0;
    end else if (accept && sel_oor && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign err_cnt_o = err_cnt;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Bench for mux_nto1_pipe: directed cases on 4- and 3-input instances, randomised
// streaming on a 16x8 instance against a capacity-2 queue model.
module tb_mux_nto1_pipe;

`ifdef MUX_SEL_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  // 4-input, 32-bit instance
  logic [127:0] d4_data;
  logic [1:0]   d4_sel;
  logic         d4_vld, d4_rdy, d4_qv, d4_rdyi;
  logic [31:0]  d4_q;
  logic [7:0]   d4_err;

  // 3-input, 32-bit instance
  logic [95:0]  d3_data;
  logic [1:0]   d3_sel;
  logic         d3_vld, d3_rdy, d3_qv, d3_rdyi;
  logic [31:0]  d3_q;
  logic [7:0]   d3_err;

  // 16-input, 8-bit instance
  logic [127:0] d16_data;
  logic [3:0]   d16_sel;
  logic         d16_vld, d16_rdy, d16_qv, d16_rdyi;
  logic [7:0]   d16_q;
  logic [7:0]   d16_err;

  mux_nto1_pipe #(.SIZE(32), .NUM_IN(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst_n), .data_i(d4_data), .select_i(d4_sel), .valid_i(d4_vld),
    .ready_o(d4_rdy), .data_o(d4_q), .valid_o(d4_qv), .ready_i(d4_rdyi), .err_cnt_o(d4_err));

  mux_nto1_pipe #(.SIZE(32), .NUM_IN(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst_n), .data_i(d3_data), .select_i(d3_sel), .valid_i(d3_vld),
    .ready_o(d3_rdy), .data_o(d3_q), .valid_o(d3_qv), .ready_i(d3_rdyi), .err_cnt_o(d3_err));

  mux_nto1_pipe #(.SIZE(8), .NUM_IN(16)) u_dut16 (
    .clk_i(clk), .rst_i(rst_n), .data_i(d16_data), .select_i(d16_sel), .valid_i(d16_vld),
    .ready_o(d16_rdy), .data_o(d16_q), .valid_o(d16_qv), .ready_i(d16_rdyi), .err_cnt_o(d16_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference for the 16-input instance: a FIFO of at most two selected values.
  logic [7:0] q16[$];
  int         n_push = 0;
  int         n_pop  = 0;

  always @(posedge clk or negedge rst_n) begin : model16
    bit         m_pop, m_acc;
    int         idx;
    logic [7:0] v;
    if (!rst_n) begin
      q16.delete();
    end else begin
      m_pop = (q16.size() > 0) && d16_rdyi;
      m_acc = d16_vld && (q16.size() < 2);
      idx   = (int'(d16_sel) < 16) ? int'(d16_sel) : 0;
      v     = d16_data[idx*8 +: 8];
      if (m_pop) begin
        void'(q16.pop_front());
        n_pop++;
      end
      if (m_acc) begin
        q16.push_back(v);
        n_push++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m16_valid", 32'(d16_qv), 32'(q16.size() > 0));
      chk("m16_ready", 32'(d16_rdy), 32'(q16.size() < 2));
      if (q16.size() > 0) chk("m16_data", 32'(d16_q), 32'(q16[0]));
      chk("m16_err", 32'(d16_err), 32'd0);
    end
  end

  initial begin
    rst_n   = 1'b0;
    d4_data = {32'h44, 32'h33, 32'h22, 32'h11};
    d4_sel  = '0; d4_vld = 1'b0; d4_rdyi = 1'b1;
    d3_data = {32'h2, 32'h1, 32'hAAAA_0000};
    d3_sel  = '0; d3_vld = 1'b0; d3_rdyi = 1'b1;
    d16_data = '0; d16_sel = '0; d16_vld = 1'b0; d16_rdyi = 1'b1;
    #2;
    chk("rst_valid", 32'(d4_qv), 32'd0);
    chk("rst_ready", 32'(d4_rdy), 32'd1);
    chk("rst_data", d4_q, 32'd0);
    chk("rst_err", 32'(d3_err), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // Streaming at full rate
    d4_vld = 1'b1; d4_sel = 2'd2;
    chk("s_valid_pre", 32'(d4_qv), 32'd0);
    tick();
    chk("s_valid0", 32'(d4_qv), 32'd1);
    chk("s_data0", d4_q, 32'h33);
    chk("s_ready0", 32'(d4_rdy), 32'd1);
    d4_sel = 2'd3;
    tick();
    chk("s_data1", d4_q, 32'h44);
    chk("s_ready1", 32'(d4_rdy), 32'd1);
    d4_sel = 2'd0;
    tick();
    chk("s_data2", d4_q, 32'h11);
    chk("s_ready2", 32'(d4_rdy), 32'd1);
    d4_vld = 1'b0;
    tick();
    chk("s_drain_valid", 32'(d4_qv), 32'd0);
    chk("s_drain_hold", d4_q, 32'h11);

    // Backpressure into the skid
    d4_rdyi = 1'b0; d4_vld = 1'b1; d4_sel = 2'd1;
    tick();
    chk("bp_valid1", 32'(d4_qv), 32'd1);
    chk("bp_data1", d4_q, 32'h22);
    chk("bp_ready1", 32'(d4_rdy), 32'd1);
    d4_sel = 2'd2;
    tick();
    chk("bp_ready2", 32'(d4_rdy), 32'd0);
    chk("bp_data2", d4_q, 32'h22);
    d4_sel = 2'd3;
    tick();
    chk("bp_ready3", 32'(d4_rdy), 32'd0);
    chk("bp_data3", d4_q, 32'h22);
    d4_rdyi = 1'b1;
    tick();
    chk("bp_out2", d4_q, 32'h33);
    chk("bp_ready4", 32'(d4_rdy), 32'd1);
    tick();
    chk("bp_out3", d4_q, 32'h44);
    chk("bp_valid5", 32'(d4_qv), 32'd1);
    d4_vld = 1'b0;
    tick();
    chk("bp_empty", 32'(d4_qv), 32'd0);

    // Asynchronous reset while FULL
    d4_rdyi = 1'b0; d4_vld = 1'b1; d4_sel = 2'd3;
    tick();
    tick();
    chk("ar_full", 32'(d4_rdy), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(d4_qv), 32'd0);
    chk("ar_ready", 32'(d4_rdy), 32'd1);
    chk("ar_data", d4_q, 32'd0);
    d4_vld = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    d4_data[63:32] = 32'h5; d4_sel = 2'd1; d4_vld = 1'b1; d4_rdyi = 1'b1;
    tick();
    chk("ar_first", d4_q, 32'h5);
    chk("ar_first_valid", 32'(d4_qv), 32'd1);
    d4_vld = 1'b0;
    tick();

    // Out-of-range select on the 3-input instance
    d3_vld = 1'b1; d3_sel = 2'd3;
    tick();
    chk("oor_data", d3_q, 32'hAAAA_0000);
    chk("oor_err1", 32'(d3_err), ERR_EN ? 32'd1 : 32'd0);
    d3_sel = 2'd2;
    tick();
    chk("inr_data", d3_q, 32'h2);
    chk("inr_err", 32'(d3_err), ERR_EN ? 32'd1 : 32'd0);
    d3_vld = 1'b0; d3_sel = 2'd3;
    tick();
    chk("idle_err", 32'(d3_err), ERR_EN ? 32'd1 : 32'd0);
    // Only the two accepted beats count while stalled
    d3_rdyi = 1'b0; d3_vld = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("stall_err", 32'(d3_err), ERR_EN ? 32'd3 : 32'd0);
    d3_vld = 1'b0; d3_rdyi = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("stall_data", d3_q, 32'hAAAA_0000);

    // Counter saturation
    d3_vld = 1'b1; d3_sel = 2'd3;
    for (int i = 0; i < 100; i++) tick();
    chk("sat_mid", 32'(d3_err), ERR_EN ? 32'd103 : 32'd0);
    for (int i = 0; i < 200; i++) tick();
    chk("sat_255", 32'(d3_err), ERR_EN ? 32'd255 : 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_hold", 32'(d3_err), ERR_EN ? 32'd255 : 32'd0);
    d3_sel = 2'd1;
    tick();
    chk("sat_valid_sel", 32'(d3_err), ERR_EN ? 32'd255 : 32'd0);
    chk("sat_valid_data", d3_q, 32'h1);
    d3_vld = 1'b0;
    tick();

    // Randomised streaming on the 16-input instance
    for (int c = 0; c < 10000; c++) begin
      d16_vld  = ($urandom_range(0, 3) != 0);
      d16_rdyi = ($urandom_range(0, 2) != 0);
      d16_sel  = 4'($urandom_range(0, 15));
      d16_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    d16_vld = 1'b0; d16_rdyi = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("rnd_drained", 32'(d16_qv), 32'd0);
    chk("rnd_balance", 32'(n_pop), 32'(n_push));
    chk("rnd_traffic", 32'(n_push > 1000), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
